rc4_encrypter: RTL
==================

# rc4_encrypter

Encrypts a fixed-length plaintext message with RC4 under a 24-bit secret key and writes the ciphertext into the encrypted-message RAM. It performs its own S-box initialisation, key schedule (KSA) and keystream generation (PRGA) on the shared 256×8 S-box RAM. Its output is exactly the ciphertext the decrypter consumes. It produces test messages on the DE1-SoC and checks decrypt round-trips.

## Interface
- MSG_LEN, 32, number of message bytes (legal 1..64)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; sampled on clk rising edge
- start  in  1  begin encryption; sampled only in IDLE or DONE
- secret_key  in  24  RC4 key; key byte 0 = [23:16], byte 1 = [15:8], byte 2 = [7:0]; must be held stable while busy
- ram_q  in  8  S-box RAM read data
- ram_address  out  8  S-box RAM address (registered)
- ram_data  out  8  S-box RAM write data (registered)
- ram_wren  out  1  S-box RAM write enable, one-cycle pulses
- pt_q  in  8  plaintext ROM read data
- pt_addr  out  6  plaintext ROM address
- ct_addr  out  6  ciphertext RAM address
- ct_data  out  8  ciphertext byte
- ct_wren  out  1  ciphertext RAM write enable, one-cycle pulse per byte
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high while in DONE

## Operation
- Memory read latency: data is sampled two cycles after the cycle in which the address register is loaded (SET → WAIT → CAPTURE). This applies to the S-box RAM and the plaintext ROM.
- All index and byte arithmetic is modulo 256 (8-bit wrap). The key index kidx cycles through 0,1,2 and resets with i.
- IDLE: if start is high, clear i, j, k and kidx, then go to INIT.
- INIT: each cycle, write S[i]=i (ram_address=i, ram_data=i, ram_wren=1) and increment i. After i=255 is written, i wraps to 0, then go to KSA.
- KSA, one iteration per i = 0..255, 9 cycles each:
  - K_RD_I: address ← i. K_W1: wait. K_CAP_I: si ← ram_q.
  - K_J: j ← j + si + key[kidx].
  - K_RD_J: address ← j. K_W2: wait. K_CAP_J: sj ← ram_q.
  - K_SW1: write S[j]=si.
  - K_SW2: write S[i]=sj; increment i and kidx (kidx wraps 2→0). If i was 255, clear i and j and go to PRGA.
- PRGA, one iteration per k = 0..MSG_LEN-1, 14 cycles each:
  - P_INC: i ← i+1.
  - P_RD_I / P_W1 / P_CAP_I: read si = S[i].
  - P_J: j ← j+si.
  - P_RD_J / P_W2 / P_CAP_J: read sj = S[j].
  - P_SW1: write S[j]=si. P_SW2: write S[i]=sj.
  - P_F: ram_address ← si+sj, and pt_addr ← k.
  - P_W3: wait.
  - P_CAP: f ← ram_q and p ← pt_q.
  - P_OUT: ct_addr ← k, ct_data ← f ^ p, ct_wren=1. If k==MSG_LEN-1, go to DONE; otherwise k ← k+1 and go to P_INC.
- DONE: hold, with done=1. If start is high, restart exactly as from IDLE.
- If i==j in a swap, both writes target the same address. The final content is sj, which equals the original value (a correct no-op).
- start is ignored while busy. Changing secret_key while busy is undefined.

## Timing
- Reset values:
  - State IDLE.
  - ram_address, ram_data, pt_addr, ct_addr and ct_data are 0.
  - ram_wren, ct_wren, busy and done are 0.
  - Internal i, j, k, kidx, si, sj and f are 0.
- Reset asserted mid-operation: on the next edge, go to IDLE with all write enables low. No partial write is issued after that edge.
- Latency: the edge that samples start is edge 0. INIT spans edges 1..256, KSA spans 2304 cycles, and PRGA spans 14·MSG_LEN cycles.
- done first reads 1 after edge 2560+14·MSG_LEN. This is 3008 for MSG_LEN=32.
- ct_wren pulses occur 14 cycles apart. The first pulse is in the cycle after edge 2560+14.
- Exactly MSG_LEN ct_wren pulses and exactly 256 + 2·256 + 2·MSG_LEN ram_wren pulses are issued per run.
- busy rises on edge 0 and falls on the same edge on which done rises.

## Test plan
- Known answer: MSG_LEN=9, key 0x4B6579 ("Key"), plaintext "Plaintext" → ciphertext BB F3 16 E8 D9 40 AF 0A D3 at ct_addr 0..8. done rises after edge 2686.
- Round-trip: MSG_LEN=32, key 0x000249, lowercase/space plaintext. Run this block, then run the decrypter on its output with the same key. The decrypter must assert done_decrypting and reproduce the plaintext byte-for-byte.
- Reset mid-KSA: assert reset at edge 1000 → IDLE next edge, all enables 0, done=0. A fresh start then gives the known-answer result and timing.
- S-box scoreboard: after INIT, check S[n]=n for all n. After KSA with key 0x4B6579, compare all 256 entries with a reference model.
- Start handling:
  - A start pulse while busy is ignored, with no timing shift.
  - A start in DONE restarts: done drops next edge, and the full sequence repeats with identical ciphertext.
- Boundaries: with MSG_LEN=1, exactly one ct write at address 0 and done after edge 2574. With MSG_LEN=64, ct_addr reaches 63 with no wrap into address 0.

Source files
------------

// File: rtl/rc4_encrypter.sv
// RC4 encrypter: S-box init, key schedule and keystream generation on a shared
// 256x8 S-box RAM, XORing the keystream with a plaintext ROM into a ciphertext RAM.
module rc4_encrypter #(
  parameter int MSG_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] secret_key,
  input  logic [7:0]  ram_q,
  output logic [7:0]  ram_address,
  output logic [7:0]  ram_data,
  output logic        ram_wren,
  input  logic [7:0]  pt_q,
  output logic [5:0]  pt_addr,
  output logic [5:0]  ct_addr,
  output logic [7:0]  ct_data,
  output logic        ct_wren,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] LAST = 6'(MSG_LEN - 1);

  typedef enum logic [4:0] {
    IDLE, INIT,
    K_RD_I, K_W1, K_CAP_I, K_J, K_RD_J, K_W2, K_CAP_J, K_SW1, K_SW2,
    P_INC, P_RD_I, P_W1, P_CAP_I, P_J, P_RD_J, P_W2, P_CAP_J, P_SW1, P_SW2,
    P_F, P_W3, P_CAP, P_OUT,
    DONE
  } state_t;

  state_t     state, state_next;
  logic [7:0] i, j, si, sj, f, p;
  logic [7:0] i_next, j_next, si_next, sj_next, f_next, p_next;
  logic [5:0] k, k_next;
  logic [1:0] kidx, kidx_next;
  logic [7:0] address_next, data_next, ct_data_next;
  logic [5:0] pt_addr_next, ct_addr_next;
  logic       wren_next, ct_wren_next;
  logic [7:0] key_byte;

  always_comb begin
    case (kidx)
      2'd0:    key_byte = secret_key[23:16];
      2'd1:    key_byte = secret_key[15:8];
      default: key_byte = secret_key[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      kidx        <= '0;
      si          <= '0;
      sj          <= '0;
      f           <= '0;
      p           <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      pt_addr     <= '0;
      ct_addr     <= '0;
      ct_data     <= '0;
      ct_wren     <= 1'b0;
    end else begin
      state       <= state_next;
      i           <= i_next;
      j           <= j_next;
      k           <= k_next;
      kidx        <= kidx_next;
      si          <= si_next;
      sj          <= sj_next;
      f           <= f_next;
      p           <= p_next;
      ram_address <= address_next;
      ram_data    <= data_next;
      ram_wren    <= wren_next;
      pt_addr     <= pt_addr_next;
      ct_addr     <= ct_addr_next;
      ct_data     <= ct_data_next;
      ct_wren     <= ct_wren_next;
    end
  end

  always_comb begin
    state_next   = state;
    i_next       = i;
    j_next       = j;
    k_next       = k;
    kidx_next    = kidx;
    si_next      = si;
    sj_next      = sj;
    f_next       = f;
    p_next       = p;
    address_next = ram_address;
    data_next    = ram_data;
    wren_next    = 1'b0;
    pt_addr_next = pt_addr;
    ct_addr_next = ct_addr;
    ct_data_next = ct_data;
    ct_wren_next = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          i_next     = '0;
          j_next     = '0;
          k_next     = '0;
          kidx_next  = '0;
          state_next = INIT;
        end
      end
      INIT: begin
        address_next = i;
        data_next    = i;
        wren_next    = 1'b1;
        i_next       = i + 8'd1;
        if (i == 8'hFF) state_next = K_RD_I;
      end
      // Key schedule: every read waits two cycles for the registered address
      K_RD_I:  begin address_next = i; state_next = K_W1; end
      K_W1:    state_next = K_CAP_I;
      K_CAP_I: begin si_next = ram_q; state_next = K_J; end
      K_J:     begin j_next = j + si + key_byte; state_next = K_RD_J; end
      K_RD_J:  begin address_next = j; state_next = K_W2; end
      K_W2:    state_next = K_CAP_J;
      K_CAP_J: begin sj_next = ram_q; state_next = K_SW1; end
      K_SW1: begin
        address_next = j;
        data_next    = si;
        wren_next    = 1'b1;
        state_next   = K_SW2;
      end
      K_SW2: begin
        address_next = i;
        data_next    = sj;
        wren_next    = 1'b1;
        i_next       = i + 8'd1;
        kidx_next    = (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
        state_next   = K_RD_I;
        if (i == 8'hFF) begin
          i_next     = '0;
          j_next     = '0;
          kidx_next  = '0;
          state_next = P_INC;
        end
      end
      P_INC:   begin i_next = i + 8'd1; state_next = P_RD_I; end
      P_RD_I:  begin address_next = i; state_next = P_W1; end
      P_W1:    state_next = P_CAP_I;
      P_CAP_I: begin si_next = ram_q; state_next = P_J; end
      P_J:     begin j_next = j + si; state_next = P_RD_J; end
      P_RD_J:  begin address_next = j; state_next = P_W2; end
      P_W2:    state_next = P_CAP_J;
      P_CAP_J: begin sj_next = ram_q; state_next = P_SW1; end
      P_SW1: begin
        address_next = j;
        data_next    = si;
        wren_next    = 1'b1;
        state_next   = P_SW2;
      end
      P_SW2: begin
        address_next = i;
        data_next    = sj;
        wren_next    = 1'b1;
        state_next   = P_F;
      end
      // Keystream byte and plaintext byte are fetched in parallel
      P_F: begin
        address_next = si + sj;
        pt_addr_next = k;
        state_next   = P_W3;
      end
      P_W3:  state_next = P_CAP;
      P_CAP: begin f_next = ram_q; p_next = pt_q; state_next = P_OUT; end
      P_OUT: begin
        ct_addr_next = k;
        ct_data_next = f ^ p;
        ct_wren_next = 1'b1;
        if (k == LAST) begin
          state_next = DONE;
        end else begin
          k_next     = k + 6'd1;
          state_next = P_INC;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

endmodule
